// File: rtl/bip_pkg.sv
// Shared widths, command bytes and state encoding for the BIP debug controller.
package bip_pkg;

  localparam int NB_OPCODE    = 5;
  localparam int NB_ADDR      = 11;
  localparam int RAM_WIDTH    = 16;
  localparam int RAM_DEPTH_PM = 2048;
  localparam int NB_BYTE      = 8;

  localparam logic [NB_OPCODE-1:0] HLT_OPCODE = 5'b00000;

  // Highest program-memory address; a load stops after writing it.
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH_PM - 1);

  // Host command bytes (ASCII).
  localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [NB_BYTE-1:0] CMD_DUMP = 8'h44;  // 'D'

  // Index of the last snapshot byte sent in a dump.
  localparam logic [2:0] DUMP_LAST_IDX = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_LO = 3'd1,
    ST_LOAD_HI = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RUN     = 3'd4,
    ST_STEP    = 3'd5,
    ST_DUMP    = 3'd6
  } state_t;

endpackage

// File: rtl/bip_dump_tx.sv
// Snapshot serializer: captures PC/ACC/counter on start and sends them
// as six bytes, low byte first, over a valid/ready byte interface.
//
// Handshake: a byte transfers on a rising clk edge where tx_valid && tx_ready.
// Once raised, tx_valid stays high and tx_data stays stable until that edge.
// The next byte is offered the cycle after a transfer (one byte per two cycles).
module bip_dump_tx
  import bip_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NB_ADDR-1:0]   pc,
  input  logic [RAM_WIDTH-1:0] acc,
  input  logic [NB_ADDR-1:0]   counter,
  output logic [NB_BYTE-1:0]   tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 done
);

  logic [NB_ADDR-1:0]   snap_pc;
  logic [RAM_WIDTH-1:0] snap_acc;
  logic [NB_ADDR-1:0]   snap_cnt;
  logic [2:0]           idx;
  logic                 busy;
  logic                 valid_q;
  logic [NB_BYTE-1:0]   byte_sel;

  // Capture the snapshot on start, then step through the six bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_pc  <= '0;
      snap_acc <= '0;
      snap_cnt <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      valid_q  <= 1'b0;
    end else if (start && !busy) begin
      snap_pc  <= pc;
      snap_acc <= acc;
      snap_cnt <= counter;
      idx      <= '0;
      busy     <= 1'b1;
      valid_q  <= 1'b1;
    end else if (valid_q && tx_ready) begin
      valid_q <= 1'b0;
      if (idx == DUMP_LAST_IDX) begin
        idx  <= '0;
        busy <= 1'b0;
      end else begin
        idx <= idx + 3'd1;
      end
    end else if (busy && !valid_q) begin
      valid_q <= 1'b1;
    end
  end

  // Select the current byte of the snapshot.
  always_comb begin
    byte_sel = '0;
    case (idx)
      3'd0:    byte_sel = snap_pc[7:0];
      3'd1:    byte_sel = {5'b0, snap_pc[10:8]};
      3'd2:    byte_sel = snap_acc[7:0];
      3'd3:    byte_sel = snap_acc[15:8];
      3'd4:    byte_sel = snap_cnt[7:0];
      3'd5:    byte_sel = {5'b0, snap_cnt[10:8]};
      default: byte_sel = '0;
    endcase
  end

  assign tx_valid = valid_q;
  assign tx_data  = valid_q ? byte_sel : '0;
  assign done     = valid_q && tx_ready && (idx == DUMP_LAST_IDX);

endmodule

// File: rtl/bip_debug_ctrl.sv
// Host-side sequencer for the BIP CPU: loads program memory from a UART
// byte stream, runs or single-steps the CPU, then dumps PC/ACC/counter.
module bip_debug_ctrl
  import bip_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NB_BYTE-1:0]   i_rx_data,
  input  logic                 i_rx_valid,
  output logic [NB_BYTE-1:0]   o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic [NB_ADDR-1:0]   i_pc,
  input  logic [RAM_WIDTH-1:0] i_acc,
  input  logic [NB_ADDR-1:0]   i_counter,
  output logic                 o_cpu_en,
  output logic                 o_cpu_rst,
  output logic                 o_pm_wr_en,
  output logic [NB_ADDR-1:0]   o_pm_addr,
  output logic [RAM_WIDTH-1:0] o_pm_data,
  output logic [2:0]           dbg_state
);

  state_t               state;
  logic [NB_ADDR-1:0]   load_addr;
  logic [NB_BYTE-1:0]   lo_byte;
  logic [NB_BYTE-1:0]   hi_byte;
  logic [RAM_WIDTH-1:0] load_word;
  logic                 cpu_rst_q;
  logic                 dump_done;
  logic                 is_hlt_word;

  assign load_word   = {hi_byte, lo_byte};
  assign is_hlt_word = (load_word[15:11] == HLT_OPCODE);

  // Main sequencer; bytes arriving outside IDLE/LOAD_LO/LOAD_HI are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      load_addr <= '0;
      lo_byte   <= '0;
      hi_byte   <= '0;
      cpu_rst_q <= 1'b0;
    end else begin
      cpu_rst_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                state     <= ST_LOAD_LO;
                load_addr <= '0;
              end
              CMD_RUN:  state <= ST_RUN;
              CMD_STEP: state <= ST_STEP;
              CMD_DUMP: state <= ST_DUMP;
              default:  state <= ST_IDLE;
            endcase
          end
        end
        ST_LOAD_LO: begin
          if (i_rx_valid) begin
            lo_byte <= i_rx_data;
            state   <= ST_LOAD_HI;
          end
        end
        ST_LOAD_HI: begin
          if (i_rx_valid) begin
            hi_byte <= i_rx_data;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // A HLT word or the top of memory ends the load; the CPU restarts at 0.
          if (is_hlt_word || (load_addr == LAST_ADDR)) begin
            state     <= ST_IDLE;
            cpu_rst_q <= 1'b1;
          end else begin
            load_addr <= load_addr + NB_ADDR'(1);
            state     <= ST_LOAD_LO;
          end
        end
        ST_RUN: begin
          if (i_opcode == HLT_OPCODE) state <= ST_DUMP;
        end
        ST_STEP: state <= ST_DUMP;
        ST_DUMP: begin
          if (dump_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The CPU clock enable is gated by HLT only while running, never while stepping.
  assign o_cpu_en = ((state == ST_RUN) && (i_opcode != HLT_OPCODE)) || (state == ST_STEP);

  assign o_cpu_rst  = cpu_rst_q;
  assign o_pm_wr_en = (state == ST_WRITE);
  assign o_pm_addr  = o_pm_wr_en ? load_addr : '0;
  assign o_pm_data  = o_pm_wr_en ? load_word : '0;
  assign dbg_state  = state;

  bip_dump_tx u_dump_tx (
    .clk      (i_clk),
    .rst      (i_rst),
    .start    (state == ST_DUMP),
    .pc       (i_pc),
    .acc      (i_acc),
    .counter  (i_counter),
    .tx_data  (o_tx_data),
    .tx_valid (o_tx_valid),
    .tx_ready (i_tx_ready),
    .done     (dump_done)
  );

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// Directed bench for bip_debug_ctrl with a small program-memory/CPU model.
module tb_bip_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [4:0]  opcode;
  logic [10:0] pc;
  logic [15:0] acc;
  logic [10:0] counter;
  logic        cpu_en;
  logic        cpu_rst;
  logic        pm_wr_en;
  logic [10:0] pm_addr;
  logic [15:0] pm_data;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Program memory and CPU model.
  logic [15:0] pm [0:2047];
  logic [10:0] m_pc = '0;
  logic [15:0] m_acc = '0;
  logic [10:0] m_cnt = '0;
  logic        model_on = 1'b1;
  logic [4:0]  man_opcode = '0;
  logic [10:0] man_pc = '0;
  logic [15:0] man_acc = '0;
  logic [10:0] man_cnt = '0;

  // Output monitors.
  int          wr_count = 0;
  int          rst_count = 0;
  int          en_count = 0;
  logic [10:0] last_addr = '0;

  assign opcode  = model_on ? pm[m_pc][15:11] : man_opcode;
  assign pc      = model_on ? m_pc : man_pc;
  assign acc     = model_on ? m_acc : man_acc;
  assign counter = model_on ? m_cnt : man_cnt;

  bip_debug_ctrl dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .i_opcode   (opcode),
    .i_pc       (pc),
    .i_acc      (acc),
    .i_counter  (counter),
    .o_cpu_en   (cpu_en),
    .o_cpu_rst  (cpu_rst),
    .o_pm_wr_en (pm_wr_en),
    .o_pm_addr  (pm_addr),
    .o_pm_data  (pm_data),
    .dbg_state  (dbg_state)
  );

  // Clock and reset-time memory fill.
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 2048; i++) pm[i] = 16'hFFFF;
  end

  // Memory write port and CPU model: ADD of the 11-bit immediate per enabled cycle.
  always @(posedge clk) begin
    if (pm_wr_en) pm[pm_addr] <= pm_data;
    if (cpu_rst) begin
      m_pc  <= '0;
      m_acc <= '0;
      m_cnt <= '0;
    end else if (cpu_en) begin
      m_pc  <= m_pc + 11'd1;
      m_acc <= m_acc + {5'b0, pm[m_pc][10:0]};
      m_cnt <= m_cnt + 11'd1;
    end
  end

  // Count strobes away from the active edge.
  always @(negedge clk) begin
    if (pm_wr_en) begin
      wr_count  = wr_count + 1;
      last_addr = pm_addr;
    end
    if (cpu_rst) rst_count = rst_count + 1;
    if (cpu_en)  en_count  = en_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle rx strobe followed by one idle cycle; called and returns at negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  // Wait (bounded) for a TX byte, compare it, then accept it for one edge.
  task automatic get_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      check({tag, "_timeout"}, {31'b0, tx_valid}, 32'd1);
    end else begin
      check(tag, {24'b0, tx_data}, {24'b0, exp});
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  int wr_base;
  int rst_base;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", {29'b0, dbg_state}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_cpu_en", {31'b0, cpu_en}, 32'd0);
    check("rst_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    check("rst_pm_wr_en", {31'b0, pm_wr_en}, 32'd0);
    check("rst_pm_addr", {21'b0, pm_addr}, 32'd0);

    // Unknown byte in IDLE is ignored
    send_byte(8'h41);
    check("ign_state", {29'b0, dbg_state}, 32'd0);
    check("ign_wr", wr_count, 32'd0);

    // Two-word load ending in HLT
    send_byte(8'h4C);
    send_byte(8'h05); send_byte(8'h08);
    send_byte(8'h00); send_byte(8'h00);
    repeat (2) @(negedge clk);
    check("ld2_wr_count", wr_count, 32'd2);
    check("ld2_pm0", {16'b0, pm[0]}, 32'h0805);
    check("ld2_pm1", {16'b0, pm[1]}, 32'h0000);
    check("ld2_rst_pulses", rst_count, 32'd1);
    check("ld2_state", {29'b0, dbg_state}, 32'd0);

    // Three-word program, run to HLT, dump with a stalled receiver
    send_byte(8'h4C);
    send_byte(8'h34); send_byte(8'h0F);
    send_byte(8'h55); send_byte(8'h0A);
    send_byte(8'h00); send_byte(8'h00);
    repeat (2) @(negedge clk);
    check("ld3_wr_count", wr_count, 32'd5);
    check("ld3_rst_pulses", rst_count, 32'd2);
    en_count = 0;
    send_byte(8'h52);
    wait_valid();
    check("run_tx_valid", {31'b0, tx_valid}, 32'd1);
    repeat (4) @(negedge clk);
    check("hold_valid", {31'b0, tx_valid}, 32'd1);
    check("hold_data", {24'b0, tx_data}, 32'h02);
    get_byte("run_pc_lo", 8'h02);
    get_byte("run_pc_hi", 8'h00);
    get_byte("run_acc_lo", 8'h89);
    get_byte("run_acc_hi", 8'h09);
    get_byte("run_cnt_lo", 8'h02);
    get_byte("run_cnt_hi", 8'h00);
    check("run_en_cycles", en_count, 32'd2);
    @(negedge clk);
    check("run_end_state", {29'b0, dbg_state}, 32'd0);
    check("run_end_valid", {31'b0, tx_valid}, 32'd0);

    // 'R' during RUN is ignored
    model_on   = 1'b0;
    man_opcode = 5'd1;
    man_pc     = 11'h123;
    man_acc    = 16'h4567;
    man_cnt    = 11'h7FE;
    wr_base    = wr_count;
    send_byte(8'h52);
    check("run2_state", {29'b0, dbg_state}, 32'd4);
    check("run2_cpu_en", {31'b0, cpu_en}, 32'd1);
    send_byte(8'h52);
    check("run2_ign_state", {29'b0, dbg_state}, 32'd4);
    check("run2_ign_wr", wr_count - wr_base, 32'd0);
    man_opcode = 5'd0;
    @(negedge clk);
    check("run2_hlt_en", {31'b0, cpu_en}, 32'd0);
    get_byte("run2_b0", 8'h23);
    get_byte("run2_b1", 8'h01);
    get_byte("run2_b2", 8'h67);
    get_byte("run2_b3", 8'h45);
    get_byte("run2_b4", 8'hFE);
    get_byte("run2_b5", 8'h07);

    // Single step while HLT is presented
    man_pc   = 11'h5A3;
    man_acc  = 16'hBEEF;
    man_cnt  = 11'h6C1;
    @(negedge clk);
    en_count = 0;
    send_byte(8'h53);
    get_byte("step_b0", 8'hA3);
    get_byte("step_b1", 8'h05);
    get_byte("step_b2", 8'hEF);
    get_byte("step_b3", 8'hBE);
    get_byte("step_b4", 8'hC1);
    get_byte("step_b5", 8'h06);
    check("step_en_cycles", en_count, 32'd1);

    // Reset in the middle of a dump
    man_pc  = 11'h2D4;
    man_acc = 16'h1357;
    man_cnt = 11'h0AB;
    @(negedge clk);
    send_byte(8'h44);
    get_byte("dmp_b0", 8'hD4);
    get_byte("dmp_b1", 8'h02);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
    check("mid_rst_state", {29'b0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h44);
    get_byte("redmp_b0", 8'hD4);
    get_byte("redmp_b1", 8'h02);
    get_byte("redmp_b2", 8'h57);
    get_byte("redmp_b3", 8'h13);
    get_byte("redmp_b4", 8'hAB);
    get_byte("redmp_b5", 8'h00);

    // Full-depth load stops at the last address
    wr_base  = wr_count;
    rst_base = rst_count;
    send_byte(8'h4C);
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] a;
      a = 11'(i);
      send_byte(a[7:0]);
      send_byte({5'b00001, a[10:8]});
    end
    repeat (2) @(negedge clk);
    check("full_wr_count", wr_count - wr_base, 32'd2048);
    check("full_last_addr", {21'b0, last_addr}, 32'h7FF);
    check("full_pm0", {16'b0, pm[0]}, 32'h0800);
    check("full_pm_last", {16'b0, pm[2047]}, 32'h0FFF);
    check("full_rst_pulse", rst_count - rst_base, 32'd1);
    check("full_state", {29'b0, dbg_state}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h08);
    check("full_no_wrap", wr_count - wr_base, 32'd2048);
    check("full_idle", {29'b0, dbg_state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bip_debug_ctrl.md
Name: bip_debug_ctrl

Overview:
- Host-side sequencer for the BIP processor, driven by a byte stream from a UART receiver.
- Loads program memory word by word, then runs the CPU to HLT or single-steps it by gating the CPU clock enable.
- After each run or step, snapshots PC, ACC and the cycle counter and returns them as 6 bytes over a ready/valid TX interface.
- Sits between the UART pair and the bips top; owns the program-memory write port and the CPU enable/reset.

Parameters:
- NB_OPCODE, 5, opcode field width (instruction bits [15:11])
- NB_ADDR, 11, program-memory address / PC width
- RAM_WIDTH, 16, instruction and ACC width
- RAM_DEPTH_PM, 2048, program-memory depth
- NB_BYTE, 8, UART byte width
- HLT_OPCODE, 5'b00000, halt opcode

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid
- o_tx_data  out  NB_BYTE  byte to transmit
- o_tx_valid  out  1  TX request; held until accepted
- i_tx_ready  in  1  transmitter accepts when valid&&ready
- i_opcode  in  NB_OPCODE  opcode of the current instruction from program memory
- i_pc  in  NB_ADDR  CPU program counter
- i_acc  in  RAM_WIDTH  CPU accumulator
- i_counter  in  NB_ADDR  cycle count from count_clock
- o_cpu_en  out  1  CPU clock enable
- o_cpu_rst  out  1  synchronous CPU/PC reset pulse
- o_pm_wr_en  out  1  program-memory write enable; also selects this block as the PM address source
- o_pm_addr  out  NB_ADDR  program-memory write address
- o_pm_data  out  RAM_WIDTH  program-memory write data

Behaviour:
- Reset: state=IDLE; all outputs 0; the load address, byte phase and snapshot registers are 0. Reset asserted mid-operation aborts immediately. A partially loaded program stays in memory.
- States: IDLE, LOAD_LO, LOAD_HI, WRITE, RUN, STEP, DUMP.
- Commands are accepted only in IDLE, on i_rx_valid:
  - 0x4C 'L' -> LOAD_LO, load address = 0
  - 0x52 'R' -> RUN
  - 0x53 'S' -> STEP
  - 0x44 'D' -> DUMP
  - Any other byte is ignored; state stays IDLE.
- LOAD_LO: on i_rx_valid, latch the low byte -> LOAD_HI.
- LOAD_HI: on i_rx_valid, latch the high byte -> WRITE.
- WRITE (exactly 1 cycle): o_pm_wr_en=1, o_pm_addr=load address, o_pm_data={hi,lo}. Next state:
  - If data[15:11]==HLT_OPCODE, or load address==RAM_DEPTH_PM-1: -> IDLE and pulse o_cpu_rst for 1 cycle (next cycle).
  - Otherwise: load address+1 -> LOAD_LO.
- Bytes arriving in WRITE, RUN, STEP or DUMP are dropped. There is no buffering.
- RUN: o_cpu_en = (state==RUN) && (i_opcode != HLT_OPCODE), combinational on i_opcode. On the first cycle with i_opcode==HLT -> DUMP. If HLT is already present at entry, the CPU gets 0 enabled cycles.
- STEP: o_cpu_en=1 for exactly 1 cycle, then -> DUMP. It is not gated by HLT.
- DUMP:
  - On entry, snapshot pc, acc and counter in the same cycle.
  - Send 6 bytes in order: PC[7:0], {5'b0,PC[10:8]}, ACC[7:0], ACC[15:8], CNT[7:0], {5'b0,CNT[10:8]}.
  - o_tx_valid is held with stable data until i_tx_ready. The next byte is presented the cycle after acceptance, so max throughput is 1 byte per 2 cycles.
  - After the 6th byte is accepted -> IDLE; o_tx_valid=0.
- o_cpu_en is 0 in every state except RUN and STEP. o_pm_wr_en is 1 only in WRITE.
- Byte counter is 3 bits and wraps 5->0 only on DUMP exit.

Decomposition:
- Package bip_pkg holds:
  - the width constants (NB_OPCODE, NB_ADDR, RAM_WIDTH, NB_BYTE)
  - HLT_OPCODE
  - command byte constants CMD_LOAD/RUN/STEP/DUMP
  - the state encoding typedef
- One natural sub-module: bip_dump_tx, a 6-byte snapshot serializer with a ready/valid handshake.

Test Plan:
- Reset mid-DUMP (after 2 bytes) -> o_tx_valid=0 next cycle; state IDLE; a 'D' afterwards restarts from byte 0.
- 'L', 0x05,0x08, 0x00,0x00 -> PM[0]=0x0805, PM[1]=0x0000; exactly 2 WRITE cycles; o_cpu_rst pulses once; then IDLE.
- Load 3 words ending in HLT, then 'R' -> o_cpu_en high until i_opcode==0; DUMP emits the PC, ACC and CNT bytes matching the model; tx_ready held low for 4 cycles keeps o_tx_data stable.
- 'S' -> o_cpu_en high exactly 1 cycle even if i_opcode==HLT; 6 bytes follow.
- 'L' followed by 2048 non-HLT words -> last write at address 0x7FF; returns to IDLE without wrapping to 0.
- Bytes 0x41 in IDLE, and 'R' during RUN -> ignored; no state change; no PM write.
